// File: rtl/mem_access_unit_if.sv
// Memory bus between mem_access_unit (master) and the shared instruction/data memory (slave).
// Request/grant handshake for the address phase, rvalid for returning read data.
interface mem_access_unit_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory sequencer: turns controller strobes into req/gnt/rvalid transactions and holds
// the instruction register and the two memory-output registers.
module mem_access_unit #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IRWrite,
    input  logic              MemO1WRT,
    input  logic              MemO2WRT,
    input  logic              MemWrite,
    input  logic [AW-1:0]     PC,
    input  logic [AW-1:0]     Addr1,
    input  logic [AW-1:0]     Addr2,
    input  logic [DW-1:0]     WData,
    output logic [DW-1:0]     Instr,
    output logic [4:0]        Opcode,
    output logic [DW-1:0]     MemOut1,
    output logic [DW-1:0]     MemOut2,
    output logic              Busy,
    output logic              Err,
    mem_access_unit_if.master mem
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StReq2, StWait2} state_e;
    typedef enum logic [2:0] {KindIr, KindRd1, KindRd2, KindDual, KindWr} kind_e;

    state_e        state_q;
    kind_e         kind_q;
    kind_e         kind_d;
    logic [AW-1:0] addr2_q;
    logic [AW-1:0] first_addr;
    logic [3:0]    strobes;
    logic          legal;
    logic          in_wait;

    assign strobes = {IRWrite, MemO1WRT, MemO2WRT, MemWrite};
    assign Busy    = (state_q != StIdle);
    assign Opcode  = Instr[DW-1 -: 5];
    assign in_wait = (state_q == StWait) || (state_q == StWait2);

    // Decode the strobe set; anything outside the five legal sets is a protocol error.
    always_comb begin
        legal  = 1'b1;
        kind_d = KindIr;
        case (strobes)
            4'b1000: kind_d = KindIr;
            4'b0100: kind_d = KindRd1;
            4'b0010: kind_d = KindRd2;
            4'b0110: kind_d = KindDual;
            4'b0001: kind_d = KindWr;
            default: legal  = 1'b0;
        endcase
    end

    always_comb begin
        first_addr = Addr1;
        if (kind_d == KindIr) begin
            first_addr = PC;
        end else if (kind_d == KindRd2) begin
            first_addr = Addr2;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q       <= StIdle;
            kind_q        <= KindIr;
            addr2_q       <= '0;
            Instr         <= '0;
            MemOut1       <= '0;
            MemOut2       <= '0;
            Err           <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            // Strobes while busy and stray read data are flagged and otherwise ignored.
            if ((Busy && (|strobes)) || (mem.mem_rvalid && !in_wait)) begin
                Err <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (|strobes) begin
                        if (legal) begin
                            kind_q        <= kind_d;
                            addr2_q       <= Addr2;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= (kind_d == KindWr);
                            mem.mem_addr  <= first_addr;
                            mem.mem_wdata <= WData;
                            state_q       <= StReq;
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        if (kind_q == KindWr) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem.mem_rvalid) begin
                        case (kind_q)
                            KindIr:  Instr   <= mem.mem_rdata;
                            KindRd2: MemOut2 <= mem.mem_rdata;
                            default: MemOut1 <= mem.mem_rdata;
                        endcase
                        if (kind_q == KindDual) begin
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= addr2_q;
                            state_q      <= StReq2;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StReq2: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        state_q     <= StWait2;
                    end
                end
                StWait2: begin
                    if (mem.mem_rvalid) begin
                        MemOut2 <= mem.mem_rdata;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a bench-side memory responder, a transaction-level
// reference model compared every cycle, and hand-computed literal expectations.
module tb_mem_access_unit;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          IRWrite = 1'b0, MemO1WRT = 1'b0, MemO2WRT = 1'b0, MemWrite = 1'b0;
    logic [AW-1:0] PC = '0, Addr1 = '0, Addr2 = '0;
    logic [DW-1:0] WData = '0;
    logic [DW-1:0] Instr, MemOut1, MemOut2;
    logic [4:0]    Opcode;
    logic          Busy, Err;

    mem_access_unit_if #(.AW(AW), .DW(DW)) mbus ();

    mem_access_unit #(.AW(AW), .DW(DW)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .IRWrite  (IRWrite),
        .MemO1WRT (MemO1WRT),
        .MemO2WRT (MemO2WRT),
        .MemWrite (MemWrite),
        .PC       (PC),
        .Addr1    (Addr1),
        .Addr2    (Addr2),
        .WData    (WData),
        .Instr    (Instr),
        .Opcode   (Opcode),
        .MemOut1  (MemOut1),
        .MemOut2  (MemOut2),
        .Busy     (Busy),
        .Err      (Err),
        .mem      (mbus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h0010: mem_rd = 16'hF800;
            16'h0100: mem_rd = 16'hAAAA;
            16'h0200: mem_rd = 16'h5555;
            default:  mem_rd = a ^ 16'hC3C3;
        endcase
    endfunction

    // Memory responder: drives gnt/rvalid on the falling edge.
    int          gnt_delay = 0, rv_delay = 0, req_cycles = 0, rd_cnt = 0, wr_count = 0;
    logic        rd_pend = 1'b0, inj_rv = 1'b0;
    logic [15:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic [15:0] req_log[$];

    initial begin
        mbus.mem_gnt = 1'b0;
        mbus.mem_rvalid = 1'b0;
        mbus.mem_rdata = '0;
    end

    always @(negedge CLK or negedge Reset) begin
        if (!Reset) begin
            mbus.mem_gnt = 1'b0;
            mbus.mem_rvalid = 1'b0;
            mbus.mem_rdata = '0;
            rd_pend = 1'b0;
            req_cycles = 0;
        end else begin
            mbus.mem_gnt = 1'b0;
            mbus.mem_rvalid = 1'b0;
            if (inj_rv) begin
                mbus.mem_rvalid = 1'b1;
                mbus.mem_rdata = 16'hDEAD;
                inj_rv = 1'b0;
            end else if (rd_pend) begin
                if (rd_cnt == 0) begin
                    mbus.mem_rvalid = 1'b1;
                    mbus.mem_rdata = mem_rd(rd_addr);
                    rd_pend = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if (mbus.mem_req === 1'b1) begin
                if (req_cycles >= gnt_delay) begin
                    mbus.mem_gnt = 1'b1;
                    req_cycles = 0;
                    req_log.push_back(mbus.mem_addr);
                    if (mbus.mem_we) begin
                        wr_addr = mbus.mem_addr;
                        wr_data = mbus.mem_wdata;
                        wr_count++;
                    end else begin
                        rd_pend = 1'b1;
                        rd_cnt = rv_delay;
                        rd_addr = mbus.mem_addr;
                    end
                end else begin
                    req_cycles++;
                end
            end
        end
    end

    // Reference model: queue of requests still to be granted, queue of reads awaiting data.
    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          tgt;  // 0=Instr 1=MemOut1 2=MemOut2 3=store
    } req_t;

    req_t        exp_q[$];
    int          rd_q[$];
    logic [15:0] e_instr = '0, e_mo1 = '0, e_mo2 = '0;
    logic        e_err = 1'b0;
    bit          m_busy, m_req, m_wait;
    int          m_tgt;
    req_t        m_r;
    logic [3:0]  m_s;

    function automatic req_t mk(input logic [15:0] a, input logic w, input logic [15:0] d,
                                input int t);
        req_t r;
        r.addr = a;
        r.we = w;
        r.wdata = d;
        r.tgt = t;
        return r;
    endfunction

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            exp_q.delete();
            rd_q.delete();
            e_instr = '0;
            e_mo1 = '0;
            e_mo2 = '0;
            e_err = 1'b0;
        end else begin
            m_busy = (exp_q.size() != 0) || (rd_q.size() != 0);
            m_req  = (exp_q.size() != 0) && (rd_q.size() == 0);
            m_wait = (rd_q.size() != 0);
            if (mbus.mem_rvalid) begin
                if (m_wait) begin
                    m_tgt = rd_q.pop_front();
                    if (m_tgt == 0) e_instr = mbus.mem_rdata;
                    else if (m_tgt == 1) e_mo1 = mbus.mem_rdata;
                    else e_mo2 = mbus.mem_rdata;
                end else begin
                    e_err = 1'b1;
                end
            end
            if (mbus.mem_gnt && m_req) begin
                m_r = exp_q.pop_front();
                if (!m_r.we) rd_q.push_back(m_r.tgt);
            end
            m_s = {IRWrite, MemO1WRT, MemO2WRT, MemWrite};
            if (m_s != 4'b0000) begin
                if (m_busy) begin
                    e_err = 1'b1;
                end else begin
                    case (m_s)
                        4'b1000: exp_q.push_back(mk(PC, 1'b0, WData, 0));
                        4'b0100: exp_q.push_back(mk(Addr1, 1'b0, WData, 1));
                        4'b0010: exp_q.push_back(mk(Addr2, 1'b0, WData, 2));
                        4'b0110: begin
                            exp_q.push_back(mk(Addr1, 1'b0, WData, 1));
                            exp_q.push_back(mk(Addr2, 1'b0, WData, 2));
                        end
                        4'b0001: exp_q.push_back(mk(Addr1, 1'b1, WData, 3));
                        default: e_err = 1'b1;
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge CLK) begin
        chk("instr", Instr, e_instr);
        chk("opcode", Opcode, e_instr[15:11]);
        chk("memout1", MemOut1, e_mo1);
        chk("memout2", MemOut2, e_mo2);
        chk("err", Err, e_err);
        chk("busy", Busy, (exp_q.size() != 0) || (rd_q.size() != 0));
        chk("mem_req", mbus.mem_req, (exp_q.size() != 0) && (rd_q.size() == 0));
        if ((exp_q.size() != 0) && (rd_q.size() == 0)) begin
            chk("mem_addr", mbus.mem_addr, exp_q[0].addr);
            chk("mem_we", mbus.mem_we, exp_q[0].we);
            if (exp_q[0].we) chk("mem_wdata", mbus.mem_wdata, exp_q[0].wdata);
        end
        if (!Reset) begin
            chk("rst_addr", mbus.mem_addr, 0);
            chk("rst_we", mbus.mem_we, 0);
            chk("rst_wdata", mbus.mem_wdata, 0);
        end
    end

    task automatic pulse(input logic [3:0] s);
        {IRWrite, MemO1WRT, MemO2WRT, MemWrite} = s;
        @(posedge CLK);
        @(negedge CLK);
        {IRWrite, MemO1WRT, MemO2WRT, MemWrite} = 4'b0000;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (Busy && n < max) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        if (Busy) begin
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle within %0d cycles", max);
        end
    endtask

    int n;

    initial begin
        #1 Reset = 1'b0;
        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            {IRWrite, MemO1WRT, MemO2WRT, MemWrite} = 4'($urandom);
            PC = 16'($urandom);
            Addr1 = 16'($urandom);
            Addr2 = 16'($urandom);
            WData = 16'($urandom);
        end
        @(negedge CLK);
        chk("rst_instr_lit", Instr, 0);
        chk("rst_opcode_lit", Opcode, 0);
        chk("rst_mo1_lit", MemOut1, 0);
        chk("rst_mo2_lit", MemOut2, 0);
        chk("rst_busy_lit", Busy, 0);
        chk("rst_err_lit", Err, 0);
        chk("rst_req_lit", mbus.mem_req, 0);
        {IRWrite, MemO1WRT, MemO2WRT, MemWrite} = 4'b0000;
        Reset = 1'b1;

        // Instruction fetch, minimum latency.
        @(negedge CLK);
        PC = 16'h0010;
        gnt_delay = 0;
        rv_delay = 0;
        pulse(4'b1000);
        wait_idle(20, n);
        chk("ir_busy_cycles", n, 2);
        chk("ir_instr_lit", Instr, 16'hF800);
        chk("ir_opcode_lit", Opcode, 5'b11111);
        chk("ir_busy_low_lit", Busy, 0);

        // Dual read with two-cycle grant delay on each request.
        Addr1 = 16'h0100;
        Addr2 = 16'h0200;
        gnt_delay = 2;
        req_log.delete();
        pulse(4'b0110);
        wait_idle(40, n);
        chk("dual_busy_cycles", n, 8);
        chk("dual_req_count", req_log.size(), 2);
        if (req_log.size() == 2) begin
            chk("dual_req0_addr", req_log[0], 16'h0100);
            chk("dual_req1_addr", req_log[1], 16'h0200);
        end
        chk("dual_mo1_lit", MemOut1, 16'hAAAA);
        chk("dual_mo2_lit", MemOut2, 16'h5555);

        // Store with grant withheld three cycles.
        Addr1 = 16'h0300;
        WData = 16'h1234;
        gnt_delay = 3;
        pulse(4'b0001);
        wait_idle(40, n);
        chk("st_busy_cycles", n, 4);
        chk("st_count", wr_count, 1);
        chk("st_addr", wr_addr, 16'h0300);
        chk("st_data", wr_data, 16'h1234);
        chk("st_instr_hold", Instr, 16'hF800);
        chk("st_mo1_hold", MemOut1, 16'hAAAA);
        chk("st_mo2_hold", MemOut2, 16'h5555);

        // Illegal strobe set.
        gnt_delay = 0;
        pulse(4'b1001);
        chk("illegal_req", mbus.mem_req, 0);
        chk("illegal_busy", Busy, 0);
        chk("illegal_err", Err, 1);

        // Strobe while busy is ignored.
        Addr1 = 16'h0400;
        gnt_delay = 1;
        pulse(4'b0100);
        PC = 16'h0000;
        pulse(4'b1000);
        wait_idle(40, n);
        chk("busy_strobe_cycles", n, 2);
        chk("busy_strobe_mo1", MemOut1, 16'hC7C3);
        chk("busy_strobe_instr", Instr, 16'hF800);
        chk("busy_strobe_err", Err, 1);

        // Spurious rvalid in idle changes nothing.
        inj_rv = 1'b1;
        repeat (3) @(negedge CLK);
        chk("spur_instr", Instr, 16'hF800);
        chk("spur_mo1", MemOut1, 16'hC7C3);
        chk("spur_mo2", MemOut2, 16'h5555);
        chk("spur_err", Err, 1);

        // Reset while waiting for read data takes effect without a clock edge.
        Addr1 = 16'h0500;
        gnt_delay = 0;
        rv_delay = 3;
        pulse(4'b0100);
        @(posedge CLK);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_req", mbus.mem_req, 0);
        chk("midrst_mo1", MemOut1, 0);
        chk("midrst_instr", Instr, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_err", Err, 0);
        @(negedge CLK);
        Reset = 1'b1;
        rv_delay = 0;
        @(negedge CLK);
        PC = 16'h0010;
        pulse(4'b1000);
        wait_idle(20, n);
        chk("post_rst_cycles", n, 2);
        chk("post_rst_instr", Instr, 16'hF800);
        chk("post_rst_err", Err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
